decoder_state_reg: RTL and testbench
====================================

// Module: decoder_state_reg
// PURPOSE
//  Fetch->decode pipeline register for the RAPID-X core (instantiated as decoder_state).
//  Captures the fetched instruction word and its PC on each rising clock edge.
//  Presents both, plus pre-sliced RV32 fields, to the decode stage one cycle later.
//  Supports stall (hold) and flush (bubble insertion).
// PARAMETERS
//  XLEN       32            datapath width; matches rapid_pkg::XLEN
//  RESET_PC   32'h0000_0000 o_pc value after reset
//  NOP_INSTR  32'h0000_0013 bubble instruction (addi x0,x0,0)
// PORTS
//  i_clk          in   1     rising-edge clock; the only clock
//  i_reset        in   1     synchronous, active-high reset
//  i_pc           in   XLEN  PC of the fetched instruction
//  i_instruction  in   XLEN  fetched instruction word
//  i_stall        in   1     1 = hold all outputs; tie 0 if unused
//  i_flush        in   1     1 = load bubble; tie 0 if unused
//  o_pc           out  XLEN  registered PC
//  o_instruction  out  XLEN  registered instruction
//  o_valid        out  1     1 = o_instruction is real; 0 = bubble or reset
//  o_opcode       out  7     o_instruction[6:0]
//  o_rd           out  5     o_instruction[11:7]
//  o_funct3       out  3     o_instruction[14:12]
//  o_rs1          out  5     o_instruction[19:15]
//  o_rs2          out  5     o_instruction[24:20]
//  o_funct7       out  7     o_instruction[31:25]
// BEHAVIOUR
//  - All state updates on the rising edge of i_clk. No combinational path from inputs to outputs.
//  - Field outputs are pure slices of the registered o_instruction, so they are always consistent with it.
//  - Priority at each edge, highest first:
//    1. i_reset=1: o_pc<=RESET_PC, o_instruction<=NOP_INSTR, o_valid<=0.
//    2. i_flush=1: o_pc<=i_pc, o_instruction<=NOP_INSTR, o_valid<=0. Flush overrides stall.
//    3. i_stall=1: all registers hold their current values.
//    4. Otherwise: o_pc<=i_pc, o_instruction<=i_instruction, o_valid<=1.
//  - Latency: exactly 1 cycle. A value applied before edge N is visible on the outputs after edge N.
//  - An undriven or X i_stall/i_flush must not block the load path in simulation. Code the load as
//    the final else of "if(i_reset) / else if(i_flush) / else if(i_stall) / else".
//  - Values are passed bit-exact; no alignment check and no width change.
//  - Reset asserted mid-stream overrides everything at that edge; loading resumes on the first
//    edge with i_reset=0.
//  - Back-to-back loads with new data every cycle are supported; there are no bubbles unless
//    flush is asserted.
// TESTING
//  - Reset: i_reset=1 for 1 edge -> o_pc=0, o_instruction=32'h13, o_valid=0.
//  - Pass-through: 100 random {i_pc,i_instruction}, one edge each -> outputs equal inputs
//    after each edge, o_valid=1.
//  - Fields: load 32'hFE20_8FA3 -> opcode=7'h23, rd=5'h1F, funct3=0, rs1=1, rs2=2, funct7=7'h7F.
//  - Stall: load pc=32'h100; then i_stall=1 with pc=32'h104 for 3 edges -> o_pc stays 32'h100.
//  - Flush vs stall: i_stall=1, i_flush=1, pc=32'h200 -> o_pc=32'h200, o_instruction=32'h13,
//    o_valid=0.
//  - Reset mid-stream: random loads, then i_reset=1 for one edge -> reset values;
//    next normal edge loads again.

Source files
------------

// File: rtl/decoder_state_reg.sv
// Fetch->decode pipeline register: captures PC and instruction word each cycle,
// with stall (hold) and flush (bubble) control, and exposes pre-sliced RV32 fields.
module decoder_state_reg #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_instruction,
   input  logic            i_stall,
   input  logic            i_flush,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_instruction,
   output logic            o_valid,
   output logic [6:0]      o_opcode,
   output logic [4:0]      o_rd,
   output logic [2:0]      o_funct3,
   output logic [4:0]      o_rs1,
   output logic [4:0]      o_rs2,
   output logic [6:0]      o_funct7
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic            valid_q, valid_d;

   // The load is the final else so an unknown stall/flush falls through to loading.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (i_flush) begin
         pc_d    = i_pc;
         instr_d = XLEN'(NOP_INSTR);
         valid_d = 1'b0;
      end else if (i_stall) begin
         pc_d    = pc_q;
         instr_d = instr_q;
         valid_d = valid_q;
      end else begin
         pc_d    = i_pc;
         instr_d = i_instruction;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc_q    <= XLEN'(RESET_PC);
         instr_q <= XLEN'(NOP_INSTR);
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign o_pc          = pc_q;
   assign o_instruction = instr_q;
   assign o_valid       = valid_q;

   // Fields are slices of the registered word, never of the input.
   assign o_opcode = instr_q[6:0];
   assign o_rd     = instr_q[11:7];
   assign o_funct3 = instr_q[14:12];
   assign o_rs1    = instr_q[19:15];
   assign o_rs2    = instr_q[24:20];
   assign o_funct7 = instr_q[31:25];

endmodule

// File: tb/tb_decoder_state_reg.sv
// Directed and random checks of decoder_state_reg against a priority-rule reference model.
module tb_decoder_state_reg;

   logic        i_clk = 1'b0;
   logic        i_reset, i_stall, i_flush;
   logic [31:0] i_pc, i_instruction;
   logic [31:0] o_pc, o_instruction;
   logic        o_valid;
   logic [6:0]  o_opcode, o_funct7;
   logic [4:0]  o_rd, o_rs1, o_rs2;
   logic [2:0]  o_funct3;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_pc, m_instr;
   logic        m_valid;

   decoder_state_reg dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_pc(i_pc), .i_instruction(i_instruction),
      .i_stall(i_stall), .i_flush(i_flush), .o_pc(o_pc), .o_instruction(o_instruction),
      .o_valid(o_valid), .o_opcode(o_opcode), .o_rd(o_rd), .o_funct3(o_funct3),
      .o_rs1(o_rs1), .o_rs2(o_rs2), .o_funct7(o_funct7)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},     o_pc, m_pc);
      check({tag, ".instr"},  o_instruction, m_instr);
      check({tag, ".valid"},  32'(o_valid), 32'(m_valid));
      check({tag, ".opcode"}, 32'(o_opcode), m_instr % 128);
      check({tag, ".rd"},     32'(o_rd),     (m_instr / 128) % 32);
      check({tag, ".funct3"}, 32'(o_funct3), (m_instr / 4096) % 8);
      check({tag, ".rs1"},    32'(o_rs1),    (m_instr / 32768) % 32);
      check({tag, ".rs2"},    32'(o_rs2),    (m_instr / 1048576) % 32);
      check({tag, ".funct7"}, 32'(o_funct7), m_instr / 33554432);
   endtask

   // Drive one cycle, update the model by the priority rules, sample after the edge.
   task automatic step(input logic rst, input logic fl, input logic st,
                       input logic [31:0] pc, input logic [31:0] ins, input string tag);
      i_reset = rst; i_flush = fl; i_stall = st; i_pc = pc; i_instruction = ins;
      @(posedge i_clk);
      if (rst) begin
         m_pc = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
      end else if (fl) begin
         m_pc = pc; m_instr = 32'h13; m_valid = 1'b0;
      end else if (st !== 1'b1) begin
         m_pc = pc; m_instr = ins; m_valid = 1'b1;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      i_reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_pc = '0; i_instruction = '0;
      m_pc = '0; m_instr = '0; m_valid = 1'b0;
      @(negedge i_clk);

      step(1, 0, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, "reset");

      for (int i = 0; i < 100; i++)
         step(0, 0, 0, $urandom, $urandom, "passthru");

      step(0, 0, 0, 32'h0000_0040, 32'hFE20_8FA3, "fields");
      check("fields.opcode_k", 32'(o_opcode), 32'h23);
      check("fields.rd_k",     32'(o_rd),     32'h1F);
      check("fields.funct3_k", 32'(o_funct3), 32'h0);
      check("fields.rs1_k",    32'(o_rs1),    32'h1);
      check("fields.rs2_k",    32'(o_rs2),    32'h2);
      check("fields.funct7_k", 32'(o_funct7), 32'h7F);

      step(0, 0, 0, 32'h100, 32'h0050_0093, "stall.load");
      for (int i = 0; i < 3; i++)
         step(0, 0, 1, 32'h104, $urandom, "stall.hold");
      check("stall.pc_k", o_pc, 32'h100);

      step(0, 1, 1, 32'h200, 32'h1234_5678, "flush_stall");
      check("flush_stall.pc_k",    o_pc, 32'h200);
      check("flush_stall.instr_k", o_instruction, 32'h13);
      check("flush_stall.valid_k", 32'(o_valid), 32'h0);

      // Stall from a bubble holds the bubble, then load resumes.
      step(0, 0, 1, 32'h300, 32'h1111_1111, "bubble.hold");
      step(0, 0, 0, 32'h304, 32'h2222_2223, "bubble.resume");

      for (int i = 0; i < 10; i++)
         step(0, 0, 0, $urandom, $urandom, "mid.load");
      step(1, 0, 1, 32'h400, 32'h3333_3333, "mid.reset");
      check("mid.reset.pc_k", o_pc, 32'h0);
      step(0, 0, 0, 32'h500, 32'h4444_4444, "mid.reload");

      // Random mix of controls.
      for (int i = 0; i < 200; i++) begin
         int r;
         r = $urandom_range(0, 9);
         step(r == 0, r == 1 || r == 2, r >= 3 && r <= 5, $urandom, $urandom, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
